// File: rtl/snn_pkg.sv
// Shared constants and weight-format helpers for the spiking perceptron.
// Weight words carry the sign in bit WIDTH and the magnitude in WIDTH-1:0.
package snn_pkg;

  function automatic int win_len(input int width);
    return (2 ** (width + 1)) + 2;
  endfunction

  function automatic int cnt_bits(input int width);
    return $clog2(win_len(width));
  endfunction

  function automatic int idx_bits(input int height);
    return (height > 1) ? $clog2(height) : 1;
  endfunction

  function automatic int bal_bits(input int width, input int height);
    return $clog2(height * (2 ** width - 1) + 1);
  endfunction

  function automatic logic w_is_neg(input logic [31:0] word, input int width);
    return word[width];
  endfunction

  function automatic logic [31:0] w_mag(input logic [31:0] word, input int width);
    return word & ((32'd1 << width) - 32'd1);
  endfunction

endpackage

// File: rtl/spike_divider.sv
// Weight-driven rate divider: a phase accumulator whose carry out is the spike.
// Over 2^WIDTH enables it emits exactly w spikes.
module spike_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] w,
  output logic             spike
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH:0]   sum;

  assign sum   = {1'b0, acc} + {1'b0, w};
  assign spike = en & sum[WIDTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/snn_perceptron.sv
// Rate-coded spiking perceptron: one pixel per window, reference train thinned or
// augmented by the pixel weight, net excess spikes per frame decide neuron_out.
module snn_perceptron
  import snn_pkg::*;
#(
  parameter int             WIDTH  = 8,
  parameter int             HEIGHT = 7,
  parameter logic [WIDTH:0] WEIGHTS [HEIGHT] =
    '{9'd60, 9'd60, 9'd60, 9'd260, 9'd260, 9'd260, 9'd260}
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [HEIGHT-1:0]                     pixels,
  output logic                                  neuron_out,
  output logic [bal_bits(WIDTH, HEIGHT)-1:0]    balance_out,
  output logic [idx_bits(HEIGHT)-1:0]           pixel_idx_out,
  output logic [cnt_bits(WIDTH)-1:0]            cnt_out,
  output logic                                  stim_out,
  output logic                                  tmp_out,
  output logic                                  pixel_pos_out,
  output logic                                  pixel_neg_out,
  output logic                                  pixel_out_out,
  output logic                                  reset_out
);

  localparam int L  = win_len(WIDTH);
  localparam int CW = cnt_bits(WIDTH);
  localparam int IW = idx_bits(HEIGHT);
  localparam int BW = bal_bits(WIDTH, HEIGHT);
  localparam int FW = BW + 1;
  localparam int SW = WIDTH + 2;

  logic [CW-1:0]    cnt;
  logic [IW-1:0]    pixel_idx;
  logic             pixel_lat;
  logic             win_start, win_end, frame_end;
  logic [WIDTH:0]   wt;
  logic [WIDTH-1:0] mag;
  logic             neg;
  logic             stim, en_pos, en_neg, tmp, pix_neg, pos_d, pixel_out;

  assign win_start = (cnt == '0);
  assign win_end   = (cnt == CW'(L - 1));
  assign frame_end = win_end && (pixel_idx == IW'(HEIGHT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      pixel_idx <= '0;
      pixel_lat <= 1'b0;
    end else begin
      if (win_end) begin
        cnt       <= '0;
        pixel_idx <= (pixel_idx == IW'(HEIGHT - 1)) ? '0 : pixel_idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      // Pixel is sampled once per window so mid-window changes are ignored.
      if (win_start) pixel_lat <= pixels[pixel_idx];
    end
  end

  assign wt   = WEIGHTS[pixel_idx];
  assign neg  = w_is_neg(32'(wt), WIDTH);
  assign mag  = WIDTH'(w_mag(32'(wt), WIDTH));
  assign stim = cnt[0] && (cnt <= CW'(2 ** (WIDTH + 1) - 1));

  assign en_pos = stim & pixel_lat & ~neg;
  assign en_neg = stim & pixel_lat & neg;

  spike_divider #(.WIDTH(WIDTH)) u_div_pos (
    .clk   (clk),
    .rst   (rst),
    .clr   (win_start),
    .en    (en_pos),
    .w     (mag),
    .spike (tmp)
  );

  spike_divider #(.WIDTH(WIDTH)) u_div_neg (
    .clk   (clk),
    .rst   (rst),
    .clr   (win_start),
    .en    (en_neg),
    .w     (mag),
    .spike (pix_neg)
  );

  // Extra spikes are pushed onto the following even cycle so they never collide with stim.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos_d <= 1'b0;
    end else if (win_start) begin
      pos_d <= 1'b0;
    end else begin
      pos_d <= tmp;
    end
  end

  assign pixel_out = (stim & ~pix_neg) | pos_d;

  logic [SW-1:0]        win_cnt, win_total;
  logic signed [FW-1:0] contrib, frame_acc, net;

  assign win_total = win_cnt + SW'(pixel_out);
  assign contrib   = $signed(FW'(win_total)) - $signed(FW'(2 ** WIDTH));
  assign net       = frame_acc + contrib;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_cnt     <= '0;
      frame_acc   <= '0;
      neuron_out  <= 1'b0;
      balance_out <= '0;
    end else begin
      win_cnt <= win_start ? '0 : win_total;
      if (frame_end) begin
        neuron_out  <= (net > 0);
        balance_out <= BW'((net < 0) ? -net : net);
        frame_acc   <= '0;
      end else if (win_end) begin
        frame_acc <= net;
      end
    end
  end

  assign pixel_idx_out = pixel_idx;
  assign cnt_out       = cnt;
  assign stim_out      = stim;
  assign tmp_out       = tmp;
  assign pixel_pos_out = pos_d;
  assign pixel_neg_out = pix_neg;
  assign pixel_out_out = pixel_out;
  assign reset_out     = ~win_start;

endmodule

// File: tb/tb_snn_perceptron.sv
// Randomized bench for snn_perceptron: frame/window expectations from a spike-count
// model are queued by the driver and popped by a free-running monitor.
module tb_snn_perceptron;

  localparam int WIDTH  = 8;
  localparam int HEIGHT = 7;
  localparam int L      = 2 ** (WIDTH + 1) + 2;
  localparam int FRAME  = HEIGHT * L;
  localparam int NSTIM  = 2 ** WIDTH;
  localparam int BW     = 11;

  localparam logic [8:0] WT0 [HEIGHT] = '{9'd60, 9'd60, 9'd60, 9'd260, 9'd260, 9'd260, 9'd260};
  localparam logic [8:0] WT1 [HEIGHT] = '{default: 9'd255};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [6:0]  pixels = '0;
  logic [6:0]  pixels1 = 7'h7F;

  logic        neuron0, stim0, tmp0, pos0, neg0, pout0, ro0;
  logic [10:0] bal0;
  logic [2:0]  idx0;
  logic [9:0]  cnt0;
  logic        neuron1, stim1, tmp1, pos1, neg1, pout1, ro1;
  logic [10:0] bal1;
  logic [2:0]  idx1;
  logic [9:0]  cnt1;

  int n_vec = 0;
  int n_err = 0;
  int n = 0;

  logic [BW:0]  exp_q[$];
  logic [27:0]  win_q[$];
  logic [BW:0]  exp1_q[$];
  logic [18:0]  win1_q[$];

  snn_perceptron u_dut0 (
    .clk(clk), .rst(rst), .pixels(pixels),
    .neuron_out(neuron0), .balance_out(bal0), .pixel_idx_out(idx0), .cnt_out(cnt0),
    .stim_out(stim0), .tmp_out(tmp0), .pixel_pos_out(pos0), .pixel_neg_out(neg0),
    .pixel_out_out(pout0), .reset_out(ro0)
  );

  snn_perceptron #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .WEIGHTS(WT1)) u_dut1 (
    .clk(clk), .rst(rst), .pixels(pixels1),
    .neuron_out(neuron1), .balance_out(bal1), .pixel_idx_out(idx1), .cnt_out(cnt1),
    .stim_out(stim1), .tmp_out(tmp1), .pixel_pos_out(pos1), .pixel_neg_out(neg1),
    .pixel_out_out(pout1), .reset_out(ro1)
  );

  // Clock and cycle reference
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) n <= 0;
    else      n <= n + 1;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model
  function automatic int w_val(input logic [8:0] w);
    return w[8] ? -int'(w[7:0]) : int'(w[7:0]);
  endfunction

  task automatic push_frame(input logic [6:0] pix);
    int net0, net1, v, abs0, abs1;
    net0 = 0;
    net1 = 0;
    for (int i = 0; i < HEIGHT; i++) begin
      v = pix[i] ? w_val(WT0[i]) : 0;
      net0 += v;
      win_q.push_back({9'((v > 0) ? v : 0), 9'((v < 0) ? -v : 0), 10'(NSTIM + v)});
      v = pixels1[i] ? w_val(WT1[i]) : 0;
      net1 += v;
      win1_q.push_back({9'((v > 0) ? v : 0), 10'(NSTIM + v)});
    end
    abs0 = (net0 < 0) ? -net0 : net0;
    abs1 = (net1 < 0) ? -net1 : net1;
    exp_q.push_back({net0 > 0, 11'(abs0)});
    exp1_q.push_back({net1 > 0, 11'(abs1)});
  endtask

  // Driver tasks
  task automatic run_cycles(input logic [6:0] pix, input int ncyc);
    logic [6:0] m;
    pixels = pix;
    for (int k = 0; k < ncyc; k++) begin
      if (k % L == 200) begin
        m = 7'($urandom_range(1, 127));
        pixels = pix ^ m;
      end else if (k % L == 400) begin
        pixels = pix;
      end
      @(posedge clk);
      #2;
    end
  endtask

  task automatic run_frame(input logic [6:0] pix);
    push_frame(pix);
    run_cycles(pix, FRAME);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_neuron0"}, neuron0, 0);
    chk({tag, "_balance0"}, bal0, 0);
    chk({tag, "_cnt0"}, cnt0, 0);
    chk({tag, "_idx0"}, idx0, 0);
    chk({tag, "_stim0"}, stim0, 0);
    chk({tag, "_tmp0"}, tmp0, 0);
    chk({tag, "_pos0"}, pos0, 0);
    chk({tag, "_neg0"}, neg0, 0);
    chk({tag, "_pout0"}, pout0, 0);
    chk({tag, "_reset_out0"}, ro0, 0);
    chk({tag, "_neuron1"}, neuron1, 0);
    chk({tag, "_balance1"}, bal1, 0);
    chk({tag, "_cnt1"}, cnt1, 0);
    chk({tag, "_pout1"}, pout1, 0);
  endtask

  // Monitor / scoreboard
  initial begin : monitor
    int ph, wi;
    int pc0, sc0, tc0, nc0, bad0, pc1, tc1, bad1;
    logic [BW:0] fe;
    logic [27:0] we;
    logic [18:0] we1;
    pc0 = 0; sc0 = 0; tc0 = 0; nc0 = 0; bad0 = 0; pc1 = 0; tc1 = 0; bad1 = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        pc0 = 0; sc0 = 0; tc0 = 0; nc0 = 0; bad0 = 0; pc1 = 0; tc1 = 0; bad1 = 0;
        continue;
      end
      ph = n % L;
      wi = (n / L) % HEIGHT;
      if (ph == 0) begin
        chk("win_start_idx", idx0, wi);
        chk("win_start_reset_out", ro0, 0);
        chk("win_start_stim", stim0, 0);
        pc0 = 0; sc0 = 0; tc0 = 0; nc0 = 0; bad0 = 0; pc1 = 0; tc1 = 0; bad1 = 0;
        if (n % FRAME == 0) begin
          if (exp_q.size() == 0 || exp1_q.size() == 0) begin
            chk("decision_without_expectation", 1, 0);
          end else begin
            fe = exp_q.pop_front();
            chk("neuron_out", neuron0, fe[BW]);
            chk("balance_out", bal0, fe[BW-1:0]);
            fe = exp1_q.pop_front();
            chk("neuron_out_w255", neuron1, fe[BW]);
            chk("balance_out_w255", bal1, fe[BW-1:0]);
          end
        end
      end else begin
        pc0 += pout0; sc0 += stim0; tc0 += tmp0; nc0 += neg0;
        if ((neg0 && !stim0) || (pos0 && stim0) || !ro0 || cnt0 != 10'(ph) || idx0 != 3'(wi))
          bad0++;
        pc1 += pout1; tc1 += tmp1;
        if ((pos1 && stim1) || neg1 || !ro1) bad1++;
        if (ph == L - 1) begin
          if (win_q.size() == 0 || win1_q.size() == 0) begin
            chk("window_without_expectation", 1, 0);
          end else begin
            we  = win_q.pop_front();
            we1 = win1_q.pop_front();
            chk("window_spikes", pc0, we[9:0]);
            chk("window_stim", sc0, NSTIM);
            chk("window_tmp", tc0, we[27:19]);
            chk("window_neg", nc0, we[18:10]);
            chk("window_timing_flags", bad0, 0);
            chk("window_spikes_w255", pc1, we1[9:0]);
            chk("window_tmp_w255", tc1, we1[18:10]);
            chk("window_flags_w255", bad1, 0);
          end
        end
      end
    end
  end

  // Stimulus sequence
  initial begin : driver
    rst = 1'b0;
    pixels = '0;
    repeat (3) @(posedge clk);
    #2;
    check_idle("reset");
    rst = 1'b1;

    run_frame(7'b0001110);
    run_frame(7'b1111000);
    run_frame(7'b0000000);
    repeat (3) run_frame(7'($urandom_range(0, 127)));

    // Partial frame cut short by reset: its expectations are discarded.
    push_frame(7'b1001011);
    run_cycles(7'b1001011, 3 * L + 123);
    rst = 1'b0;
    #1;
    check_idle("mid_reset");
    exp_q.delete();
    win_q.delete();
    exp1_q.delete();
    win1_q.delete();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;

    run_frame(7'b0001110);
    repeat (2) @(posedge clk);
    #2;
    chk("queues_drained", exp_q.size() + win_q.size() + exp1_q.size() + win1_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
